// File: rtl/swervolf_seg7_mux_if.sv
// Input/output bundle for the Basys3 seven-segment scanner.
// SWERVOLF_SEG7_DIM_EN adds the i_brightness field.
interface swervolf_seg7_mux_if;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic [3:0]  i_digit_en;
`ifdef SWERVOLF_SEG7_DIM_EN
  logic [3:0]  i_brightness;
`endif
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

`ifdef SWERVOLF_SEG7_DIM_EN
  modport master (output i_value, i_dp, i_digit_en, i_brightness,
                  input  o_an, o_seg, o_dp, o_frame);
  modport slave  (input  i_value, i_dp, i_digit_en, i_brightness,
                  output o_an, o_seg, o_dp, o_frame);
`else
  modport master (output i_value, i_dp, i_digit_en,
                  input  o_an, o_seg, o_dp, o_frame);
  modport slave  (input  i_value, i_dp, i_digit_en,
                  output o_an, o_seg, o_dp, o_frame);
`endif
endinterface

// File: rtl/swervolf_seg7_mux.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame input latch.
// Optional PWM dimming enabled by defining SWERVOLF_SEG7_DIM_EN.
module swervolf_seg7_mux #(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned REFRESH_HZ   = 250,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rstn,
  swervolf_seg7_mux_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / (4 * REFRESH_HZ);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_value_q, shadow_value_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       shadow_en_q, shadow_en_d;
  logic             frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start;
  logic             lit;
  logic [3:0]       nibble;
`ifdef SWERVOLF_SEG7_DIM_EN
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [3:0]       shadow_bright_q, shadow_bright_d;
`endif

  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    slot_cnt_d     = slot_cnt_q + 1'b1;
    idx_d          = idx_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_en_d    = shadow_en_q;
    an_d           = '1;
    seg_d          = '1;
    dp_d           = 1'b1;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    frame_start = (idx_q == 2'd0) && (slot_cnt_q == '0);
    frame_d     = frame_start;
    if (frame_start) begin
      shadow_value_d = bus.i_value;
      shadow_dp_d    = bus.i_dp;
      shadow_en_d    = bus.i_digit_en;
    end

    // Lit decision uses the frame's shadow copy so a mid-frame input change cannot tear.
    nibble = shadow_value_q[{idx_q, 2'b00} +: 4];
    lit    = (slot_cnt_q >= BLANK_END) && shadow_en_q[idx_q];

`ifdef SWERVOLF_SEG7_DIM_EN
    pwm_cnt_d       = pwm_cnt_q + 4'd1;
    shadow_bright_d = frame_start ? bus.i_brightness : shadow_bright_q;
    lit = lit && ((shadow_bright_q == 4'hF) || (pwm_cnt_q < shadow_bright_q));
`endif

    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nibble);
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt_q     <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_en_q    <= '0;
      frame_q        <= 1'b0;
      an_q           <= '1;
      seg_q          <= '1;
      dp_q           <= 1'b1;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_en_q    <= shadow_en_d;
      frame_q        <= frame_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

`ifdef SWERVOLF_SEG7_DIM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_q       <= '0;
      shadow_bright_q <= '0;
    end else begin
      pwm_cnt_q       <= pwm_cnt_d;
      shadow_bright_q <= shadow_bright_d;
    end
  end
`endif

  assign bus.o_an    = an_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_swervolf_seg7_mux.sv
// Bench for swervolf_seg7_mux: time-indexed reference model, directed plus random stimulus.
module tb_swervolf_seg7_mux;

  localparam int unsigned DIV   = 256 / (4 * 4);
  localparam int unsigned FRAME = 4 * DIV;
  localparam int unsigned BLANK = 2;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  swervolf_seg7_mux_if bus_if ();

  swervolf_seg7_mux #(
    .CLK_FREQ_HZ (256),
    .REFRESH_HZ  (4),
    .BLANK_CYCLES(2)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if.slave)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned s     = 0;
  bit          in_reset = 1'b1;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_en, m_br;
  logic [3:0]  prev_an = 4'hF;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s s=%0d got=%h exp=%h", tag, s, got, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"},    16'(bus_if.o_an),    16'hF);
    check({tag, "_seg"},   16'(bus_if.o_seg),   16'h7F);
    check({tag, "_dp"},    16'(bus_if.o_dp),    16'h1);
    check({tag, "_frame"}, 16'(bus_if.o_frame), 16'h0);
  endtask

  task automatic step();
    int unsigned d, pos;
    bit          lit;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    if (!in_reset && (s % FRAME == 0)) begin
      m_val = bus_if.i_value;
      m_dp  = bus_if.i_dp;
      m_en  = bus_if.i_digit_en;
`ifdef SWERVOLF_SEG7_DIM_EN
      m_br  = bus_if.i_brightness;
`else
      m_br  = 4'hF;
`endif
    end
    @(posedge clk);
    #1;
    if (in_reset) begin
      check_blank("rst");
    end else begin
      d     = (s / DIV) % 4;
      pos   = s % DIV;
      lit   = (pos >= BLANK) && m_en[d] && ((m_br == 4'hF) || ((s % 16) < m_br));
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit ? SEG_TAB[m_val[d*4 +: 4]] : 7'h7F;
      e_dp  = lit ? ~m_dp[d] : 1'b1;
      check("an",    16'(bus_if.o_an),    16'(e_an));
      check("seg",   16'(bus_if.o_seg),   16'(e_seg));
      check("dp",    16'(bus_if.o_dp),    16'(e_dp));
      check("frame", 16'(bus_if.o_frame), 16'(s % FRAME == 0));
      s++;
    end
    check("one_anode", 16'($countones(~bus_if.o_an) <= 1), 16'h1);
    check("an_via_blank",
          16'((prev_an == 4'hF) || (bus_if.o_an == 4'hF) || (bus_if.o_an == prev_an)), 16'h1);
    prev_an = bus_if.o_an;
  endtask

  task automatic release_reset();
    rstn     = 1'b1;
    in_reset = 1'b0;
    s        = 0;
  endtask

  initial begin
    rstn = 1'b0;
    bus_if.i_value    = 16'h1234;
    bus_if.i_dp       = 4'h0;
    bus_if.i_digit_en = 4'hF;
`ifdef SWERVOLF_SEG7_DIM_EN
    bus_if.i_brightness = 4'hF;
`endif
    m_val = '0; m_dp = '0; m_en = '0; m_br = 4'hF;
    repeat (3) step();

    // Release with 1234, swap to ABCD mid-frame: only the next frame shows it.
    release_reset();
    repeat (19) step();
    bus_if.i_value = 16'hABCD;
    repeat (80) step();

    // Digits 1 and 3 disabled for three frames, random values.
    bus_if.i_digit_en = 4'b0101;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i % 23 == 0) bus_if.i_value = 16'($urandom);
      step();
    end

    // Decimal point on digit 3 only.
    bus_if.i_digit_en = 4'hF;
    bus_if.i_dp       = 4'b1000;
    bus_if.i_value    = 16'h8000;
    repeat (2 * FRAME) step();

    // Asynchronous reset while digit 2 is lit.
    rstn = 1'b0;
    in_reset = 1'b1;
    repeat (2) step();
    release_reset();
    repeat (37) step();
    #2 rstn = 1'b0;
    #1 check_blank("async_rst");
    in_reset = 1'b1;
    prev_an  = 4'hF;
    repeat (2) step();
    release_reset();
    repeat (FRAME + 4) step();

    // Random input churn at arbitrary times.
    for (int i = 0; i < 5 * FRAME; i++) begin
      if ($urandom_range(7) == 0) begin
        bus_if.i_value    = 16'($urandom);
        bus_if.i_dp       = 4'($urandom);
        bus_if.i_digit_en = 4'($urandom);
`ifdef SWERVOLF_SEG7_DIM_EN
        bus_if.i_brightness = 4'($urandom);
`endif
      end
      step();
    end

`ifdef SWERVOLF_SEG7_DIM_EN
    bus_if.i_digit_en = 4'hF;
    bus_if.i_brightness = 4'd4;
    repeat (2 * FRAME) step();
    bus_if.i_brightness = 4'd0;
    repeat (2 * FRAME) step();
    bus_if.i_brightness = 4'd15;
    repeat (2 * FRAME) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
